// File: rtl/light_sensor_frontend.sv
// Light sensor frontend: periodic serial ADC daylight reader
// plus synchronised, debounced, hold-stretched PIR presence.
module light_sensor_frontend #(
  parameter int DAYLIGHT_W    = 8,
  parameter int SCLK_HALF     = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int DEBOUNCE      = 4,
  parameter int HOLD          = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_sdo,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  input  logic                  pir_raw,
  output logic [DAYLIGHT_W-1:0] daylight,
  output logic                  daylight_valid,
  output logic                  presence
);

  localparam int TW = (SAMPLE_PERIOD > 1) ?
                      $clog2(SAMPLE_PERIOD) : 1;
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(DAYLIGHT_W + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int LW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  localparam logic [TW-1:0] T_LAST =
    TW'(SAMPLE_PERIOD - 1);
  localparam logic [HW-1:0] H_LAST =
    HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] B_LAST =
    BW'(DAYLIGHT_W);
  localparam logic [DW-1:0] D_LAST =
    DW'(DEBOUNCE);
  localparam logic [LW-1:0] HOLD_V =
    LW'(HOLD);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT
  } state_t;

  state_t                state, state_n;
  logic [TW-1:0]         tmr;
  logic                  tick;
  logic [HW-1:0]         hc, hc_n;
  logic [BW-1:0]         bits, bits_n;
  logic [DAYLIGHT_W-1:0] sh, sh_n;
  logic [DAYLIGHT_W-1:0] day_n;
  logic                  cs_n_n;
  logic                  sclk_n;
  logic                  valid_n;
  logic                  edge_hit;

  logic                  s1, s2, db;
  logic [DW-1:0]         dcnt;
  logic [LW-1:0]         hold_cnt;

  assign tick     = (tmr == T_LAST);
  assign edge_hit = (hc == H_LAST);

  // Free-running sample timer; tick on terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr <= '0;
    end else if (tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // Conversion FSM and ADC datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hc             <= '0;
      bits           <= '0;
      sh             <= '0;
      adc_cs_n       <= 1'b1;
      adc_sclk       <= 1'b0;
      daylight       <= '0;
      daylight_valid <= 1'b0;
    end else begin
      state          <= state_n;
      hc             <= hc_n;
      bits           <= bits_n;
      sh             <= sh_n;
      adc_cs_n       <= cs_n_n;
      adc_sclk       <= sclk_n;
      daylight       <= day_n;
      daylight_valid <= valid_n;
    end
  end

  // Next state: setup gap, then toggle sclk each half
  // period, capturing sdo on every rising sclk.
  always_comb begin
    state_n = state;
    hc_n    = hc;
    bits_n  = bits;
    sh_n    = sh;
    cs_n_n  = adc_cs_n;
    sclk_n  = adc_sclk;
    day_n   = daylight;
    valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        hc_n   = '0;
        bits_n = '0;
        sclk_n = 1'b0;
        if (tick) begin
          cs_n_n  = 1'b0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (edge_hit) begin
          hc_n    = '0;
          state_n = SHIFT;
        end else begin
          hc_n = hc + 1'b1;
        end
      end
      SHIFT: begin
        if (!edge_hit) begin
          hc_n = hc + 1'b1;
        end else begin
          hc_n = '0;
          if (!adc_sclk) begin
            sclk_n = 1'b1;
            sh_n   = {sh[DAYLIGHT_W-2:0], adc_sdo};
            bits_n = bits + 1'b1;
          end else if (bits == B_LAST) begin
            sclk_n  = 1'b0;
            cs_n_n  = 1'b1;
            day_n   = sh;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            sclk_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b0;
      end
    endcase
  end

  // Two-flop synchroniser for the asynchronous PIR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pir_raw;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level once it has persisted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db   <= 1'b0;
      dcnt <= '0;
    end else if (s2 != db) begin
      if (dcnt == D_LAST) begin
        db   <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end else begin
      dcnt <= '0;
    end
  end

  // Occupancy hold: reload while motion, stretch after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      presence <= 1'b0;
    end else begin
      if (db) begin
        hold_cnt <= HOLD_V;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      presence <= db | (hold_cnt != '0);
    end
  end

endmodule

// File: tb/tb_light_sensor_frontend.sv
// Directed + randomized bench for light_sensor_frontend
// with an interval-based presence model and a serial ADC model.
module tb_light_sensor_frontend;

  localparam int W       = 8;
  localparam int HALF    = 2;
  localparam int PERIOD  = 100;
  localparam int DEB     = 4;
  localparam int HOLDC   = 10;
  localparam int CS_LOW  = HALF * (1 + 2 * W);
  localparam int ACCEPT  = DEB + 1;
  localparam int RISE    = DEB + 3;
  localparam int FALL    = DEB + 2 + HOLDC + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         adc_sdo = 1'b0;
  logic         pir_raw = 1'b0;
  logic         adc_cs_n;
  logic         adc_sclk;
  logic [W-1:0] daylight;
  logic         daylight_valid;
  logic         presence;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] adc_word = '0;
  int           idx = 0;
  logic         prev_cs = 1'b1;
  logic         prev_sclk = 1'b0;

  bit pat[$];

  light_sensor_frontend #(
    .DAYLIGHT_W    (W),
    .SCLK_HALF     (HALF),
    .SAMPLE_PERIOD (PERIOD),
    .DEBOUNCE      (DEB),
    .HOLD          (HOLDC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .adc_sdo        (adc_sdo),
    .adc_cs_n       (adc_cs_n),
    .adc_sclk       (adc_sclk),
    .pir_raw        (pir_raw),
    .daylight       (daylight),
    .daylight_valid (daylight_valid),
    .presence       (presence)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Serial ADC: MSB on select, next bit after each sclk fall.
  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      idx = W - 1;
      adc_sdo = adc_word[idx];
    end else if (!adc_cs_n && prev_sclk && !adc_sclk
                 && idx > 0) begin
      idx = idx - 1;
      adc_sdo = adc_word[idx];
    end
    prev_cs = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_conv(input string tag,
                          input logic [W-1:0] w,
                          input logic [W-1:0] prev,
                          input int exp_tcs,
                          output int tv);
    int n;
    int low;
    int rises;
    int tcs;
    logic ps;
    logic early;
    n = 0;
    while (adc_cs_n === 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    adc_word = w;
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cs_fall"}, {31'b0, adc_cs_n}, 32'd0);
    if (exp_tcs >= 0)
      chk({tag, "_t_start"}, cyc, exp_tcs);
    tcs = cyc;
    low = 0;
    rises = 0;
    ps = 1'b0;
    early = 1'b0;
    while (adc_cs_n === 1'b0 && low < 100) begin
      low++;
      if (adc_sclk === 1'b1 && ps === 1'b0) rises++;
      ps = adc_sclk;
      if (daylight_valid !== 1'b0 || daylight !== prev)
        early = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_cs_low"}, low, CS_LOW);
    chk({tag, "_rises"}, rises, W);
    chk({tag, "_early"}, {31'b0, early}, 32'd0);
    chk({tag, "_valid"}, {31'b0, daylight_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, daylight}, {24'b0, w});
    chk({tag, "_sclk"}, {31'b0, adc_sclk}, 32'd0);
    chk({tag, "_lat"}, cyc - tcs, CS_LOW);
    tv = cyc;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, daylight_valid}, 32'd0);
    chk({tag, "_hold"}, {24'b0, daylight}, {24'b0, w});
  endtask

  task automatic add(input bit v, input int len);
    repeat (len) pat.push_back(v);
  endtask

  // Presence is high over [start+RISE, end+FALL) of every
  // high run long enough to survive the debounce.
  task automatic run_pir(input string tag);
    int n;
    int k;
    int a;
    int b;
    bit e[$];
    n = pat.size();
    e = {};
    for (int i = 0; i < n; i++) e.push_back(1'b0);
    k = 0;
    while (k < n) begin
      if (pat[k]) begin
        a = k;
        while (k < n && pat[k]) k++;
        b = k;
        if (b - a >= ACCEPT)
          for (int j = a + RISE; j < b + FALL && j < n; j++)
            e[j] = 1'b1;
      end else begin
        k++;
      end
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0)
        chk($sformatf("%s[%0d]", tag, i - 1),
            {31'b0, presence}, {31'b0, e[i-1]});
      pir_raw = pat[i];
    end
    @(negedge clk);
    chk($sformatf("%s[%0d]", tag, n - 1),
        {31'b0, presence}, {31'b0, e[n-1]});
  endtask

  initial begin
    int tv1;
    int tv2;
    int n;
    int rises;
    logic ps;
    logic bad;
    logic [W-1:0] r1;
    logic [W-1:0] r2;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'b0, adc_cs_n}, 32'd1);
    chk("rst_sclk", {31'b0, adc_sclk}, 32'd0);
    chk("rst_day", {24'b0, daylight}, 32'd0);
    chk("rst_valid", {31'b0, daylight_valid}, 32'd0);
    chk("rst_pres", {31'b0, presence}, 32'd0);
    reset = 1'b0;

    run_conv("ff", 8'hFF, 8'h00, PERIOD, tv1);
    chk("ff_t_valid", tv1, PERIOD + CS_LOW);
    run_conv("a5", 8'hA5, 8'hFF, 2 * PERIOD, tv1);
    run_conv("3c", 8'h3C, 8'hA5, 3 * PERIOD, tv2);
    chk("3c_spacing", tv2 - tv1, PERIOD);

    adc_word = 8'h5A;
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    rises = 0;
    ps = 1'b0;
    n = 0;
    while (rises < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (adc_sclk === 1'b1 && ps === 1'b0) rises++;
      ps = adc_sclk;
    end
    chk("abort_rises", rises, 4);
    reset = 1'b1;
    #1;
    chk("abort_cs_n", {31'b0, adc_cs_n}, 32'd1);
    chk("abort_sclk", {31'b0, adc_sclk}, 32'd0);
    chk("abort_valid", {31'b0, daylight_valid}, 32'd0);
    chk("abort_day", {24'b0, daylight}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < PERIOD - 1; i++) begin
      @(negedge clk);
      if (daylight !== '0 || daylight_valid !== 1'b0)
        bad = 1'b1;
    end
    chk("abort_idle0", {31'b0, bad}, 32'd0);
    run_conv("post", 8'hC3, 8'h00, PERIOD, tv1);

    pat.delete();
    add(1'b0, 10); add(1'b1, 3); add(1'b0, 30);
    run_pir("pir_glitch");

    pat.delete();
    add(1'b0, 5); add(1'b1, 40); add(1'b0, 30);
    run_pir("pir_held");

    pat.delete();
    add(1'b0, 5); add(1'b1, 20); add(1'b0, 30);
    run_pir("pir_fall");

    pat.delete();
    add(1'b0, 5); add(1'b1, 20); add(1'b0, 8);
    add(1'b1, 20); add(1'b0, 30);
    run_pir("pir_renew");

    pat.delete();
    add(1'b0, 6);
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 2) == 0)
        add(1'b1, $urandom_range(1, ACCEPT - 1));
      else
        add(1'b1, $urandom_range(ACCEPT, 30));
      add(1'b0, $urandom_range(ACCEPT, 25));
    end
    add(1'b0, 25);
    r1 = W'($urandom);
    r2 = W'($urandom);
    fork
      run_pir("pir_rand");
      begin
        run_conv("rnd1", r1, 8'hC3, -1, tv1);
        run_conv("rnd2", r2, r1, -1, tv2);
        chk("rnd_spacing", tv2 - tv1, PERIOD);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
